// File: rtl/layer_pkg.sv
// Shared constants and FSM encoding for the layer-to-layer output serializer.
package layer_pkg;

    localparam int LAYER_DW      = 16;
    localparam int LAYER_NN      = 30;
    localparam int LAYER_NN_NEXT = 30;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ser_state_e;

endpackage

// File: rtl/layer_out_serializer_capture_bank.sv
// Per-lane capture registers for one batch of source-layer results, with
// arrival mask, lane re-strobe detection and batch-complete signalling.
module ser_capture_bank
    import layer_pkg::*;
#(
    parameter int NN = LAYER_NN,
    parameter int DW = LAYER_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NN-1:0]    in_valid_i,
    input  logic [NN*DW-1:0] in_data_i,
    output logic             batch_done_o,
    output logic [DW-1:0]    batch_word_o [NN],
    output logic             lane_overrun_o
);

    logic [NN-1:0] mask_q;
    logic [DW-1:0] cap_q [NN];

    // Completed batch view: words arriving on the completing edge bypass cap_q.
    always_comb begin
        for (int k = 0; k < NN; k++) begin
            batch_word_o[k] = in_valid_i[k] ? in_data_i[k*DW +: DW] : cap_q[k];
        end
    end

    assign batch_done_o   = &(mask_q | in_valid_i);
    assign lane_overrun_o = |(mask_q & in_valid_i);

    // NOTE: data-only storage is left unreset; mask_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NN; k++) begin
            if (in_valid_i[k]) begin
                cap_q[k] <= in_data_i[k*DW +: DW];
            end
        end
    end

    // No carry-over: lanes strobed on the completing edge belong to that batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (batch_done_o) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_q | in_valid_i;
        end
    end

endmodule

// File: rtl/layer_out_serializer.sv
// Double-buffered parallel-to-serial bridge between neural layers.
// Optional SER_BATCH_CNT_EN adds a 16-bit count of fully streamed batches.
module layer_out_serializer
    import layer_pkg::*;
#(
    parameter int NN      = LAYER_NN,
    parameter int NN_NEXT = LAYER_NN_NEXT,
    parameter int DW      = LAYER_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NN-1:0]         in_valid,
    input  logic [NN*DW-1:0]      in_data,
    output logic [NN_NEXT*DW-1:0] out_data,
    output logic [NN_NEXT-1:0]    out_valid,
    output logic                  busy,
    output logic                  overrun
`ifdef SER_BATCH_CNT_EN
    ,
    output logic [15:0]           batch_cnt
`endif
);

    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

    logic          batch_done;
    logic          lane_overrun;
    logic [DW-1:0] batch_word [NN];

    ser_capture_bank #(
        .NN (NN),
        .DW (DW)
    ) u_capture (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .batch_done_o   (batch_done),
        .batch_word_o   (batch_word),
        .lane_overrun_o (lane_overrun)
    );

    ser_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_next;
    logic             pend_vld_q;
    logic             valid_q;
    logic             overrun_q;
    logic [DW-1:0]    word_q;
    logic [DW-1:0]    strm_buf_q [NN];
    logic [DW-1:0]    pend_buf_q [NN];
    logic             last_word;
    logic             load_slot;

    assign idx_next  = idx_q + IDX_W'(1);
    assign last_word = (state_q == ST_STREAM) && (idx_q == IDX_W'(NN - 1));
    // The stream buffer may be (re)loaded when idle or while its last word is out.
    assign load_slot = (state_q == ST_IDLE) || last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            pend_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            word_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (lane_overrun || (batch_done && !load_slot && pend_vld_q)) begin
                overrun_q <= 1'b1;
            end
            if (load_slot) begin
                idx_q <= '0;
                if (pend_vld_q) begin
                    state_q    <= ST_STREAM;
                    valid_q    <= 1'b1;
                    word_q     <= pend_buf_q[0];
                    pend_vld_q <= batch_done;
                end else if (batch_done) begin
                    state_q <= ST_STREAM;
                    valid_q <= 1'b1;
                    word_q  <= batch_word[0];
                end else begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    word_q  <= '0;
                end
            end else begin
                idx_q  <= idx_next;
                word_q <= strm_buf_q[idx_next];
                if (batch_done && !pend_vld_q) begin
                    pend_vld_q <= 1'b1;
                end
            end
        end
    end

    // A completed batch parks in the pending buffer exactly when it cannot go
    // straight to streaming yet a free pending slot exists (load_slot == pend_vld_q).
    always_ff @(posedge clk) begin
        if (load_slot) begin
            if (pend_vld_q) begin
                strm_buf_q <= pend_buf_q;
            end else if (batch_done) begin
                strm_buf_q <= batch_word;
            end
        end
        if (batch_done && (load_slot == pend_vld_q)) begin
            pend_buf_q <= batch_word;
        end
    end

`ifdef SER_BATCH_CNT_EN
    logic [15:0] batch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            batch_cnt_q <= '0;
        end else if (last_word) begin
            batch_cnt_q <= batch_cnt_q + 16'd1;
        end
    end

    assign batch_cnt = batch_cnt_q;
`endif

    assign out_data  = {NN_NEXT{word_q}};
    assign out_valid = {NN_NEXT{valid_q}};
    assign busy      = (state_q == ST_STREAM);
    assign overrun   = overrun_q;

endmodule
